receiver: RTL and testbench

- UART serial receiver. Oversamples `serial_in` on `sample_clock` and de-frames start / `WORD_SIZE` data bits (LSB first) / stop.
- Presents the received word on `RCV_datareg` and flags completion and errors to the host.
- Sits between the async serial line pin and the host-side read interface; the transmitter is a separate block.

---
 rtl/receiver.sv | 125 ++++++++++++
 tb/tb_receiver.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/receiver.sv
// UART serial receiver.
// Oversamples serial_in on sample_clock and de-frames start / WORD_SIZE data
// bits (LSB first) / stop. A good word is loaded into RCV_datareg and
// announced with a one-cycle read_not_ready_out pulse. error1 flags an
// overrun and error2 flags a framing error; both stay set until the next
// start bit or reset.
// Optional build macro RCV_MAJORITY_EN: each data/stop bit is the majority
// of the last three samples of the bit period instead of a single sample.
module receiver #(
  parameter int WORD_SIZE  = 8,
  parameter int OVERSAMPLE = 8
) (
  input  logic                 sample_clock,
  input  logic                 resetn,
  input  logic                 serial_in,
  input  logic                 read_not_ready_in,
  output logic [WORD_SIZE-1:0] RCV_datareg,
  output logic                 read_not_ready_out,
  output logic                 error1,
  output logic                 error2
);

  localparam int SC_W = $clog2(OVERSAMPLE);
  localparam int BC_W = $clog2(WORD_SIZE + 1);

  localparam logic [SC_W-1:0] HALF_LAST = SC_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SC_W-1:0] BIT_LAST  = SC_W'(OVERSAMPLE - 1);
  localparam logic [BC_W-1:0] WORD_BITS = BC_W'(WORD_SIZE);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    RECEIVE = 2'd2
  } state_t;

  state_t               state;
  logic [SC_W-1:0]      sample_cnt;
  logic [BC_W-1:0]      bit_cnt;
  logic [WORD_SIZE-1:0] shift_reg;
  logic                 bit_val;

`ifdef RCV_MAJORITY_EN
  localparam logic [SC_W-1:0] VOTE_A = SC_W'(OVERSAMPLE - 3);
  localparam logic [SC_W-1:0] VOTE_B = SC_W'(OVERSAMPLE - 2);

  logic samp_a;
  logic samp_b;

  // Capture the two early votes of each bit period; the third is the live sample.
  always_ff @(posedge sample_clock or posedge resetn) begin
    if (resetn) begin
      samp_a <= 1'b1;
      samp_b <= 1'b1;
    end else if (state == RECEIVE) begin
      if (sample_cnt == VOTE_A) samp_a <= serial_in;
      if (sample_cnt == VOTE_B) samp_b <= serial_in;
    end
  end

  assign bit_val = (samp_a & samp_b) | (samp_a & serial_in) | (samp_b & serial_in);
`else
  assign bit_val = serial_in;
`endif

  // Frame FSM: start detect, mid-bit start confirm, data shift and stop evaluation.
  always_ff @(posedge sample_clock or posedge resetn) begin
    if (resetn) begin
      state              <= IDLE;
      sample_cnt         <= '0;
      bit_cnt            <= '0;
      shift_reg          <= '0;
      RCV_datareg        <= '0;
      read_not_ready_out <= 1'b0;
      error1             <= 1'b0;
      error2             <= 1'b0;
    end else begin
      read_not_ready_out <= 1'b0;
      case (state)
        IDLE: begin
          if (!serial_in) begin
            state      <= START;
            sample_cnt <= '0;
            error1     <= 1'b0;
            error2     <= 1'b0;
          end
        end

        START: begin
          sample_cnt <= sample_cnt + SC_W'(1);
          if (serial_in) begin
            state <= IDLE;
          end else if (sample_cnt == HALF_LAST) begin
            state      <= RECEIVE;
            sample_cnt <= '0;
            bit_cnt    <= '0;
          end
        end

        RECEIVE: begin
          sample_cnt <= sample_cnt + SC_W'(1);
          if (sample_cnt == BIT_LAST) begin
            sample_cnt <= '0;
            if (bit_cnt < WORD_BITS) begin
              shift_reg <= {bit_val, shift_reg[WORD_SIZE-1:1]};
              bit_cnt   <= bit_cnt + BC_W'(1);
            end else begin
              state <= IDLE;
              if (read_not_ready_in) begin
                error1 <= 1'b1;
              end else if (!bit_val) begin
                error2 <= 1'b1;
              end else begin
                RCV_datareg        <= shift_reg;
                read_not_ready_out <= 1'b1;
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_receiver.sv
// Directed self-checking bench for the UART receiver at default parameters.
module tb_receiver;

  localparam int WS = 8;
  localparam int OS = 8;
  localparam int EXP_LATENCY = 76;

  logic          sample_clock;
  logic          resetn;
  logic          serial_in;
  logic          read_not_ready_in;
  logic [WS-1:0] RCV_datareg;
  logic          read_not_ready_out;
  logic          error1;
  logic          error2;

  int compared;
  int mismatched;
  int cyc;
  int pulse_cnt;
  int pulse_cyc;
  int start_cyc;

  receiver #(.WORD_SIZE(WS), .OVERSAMPLE(OS)) dut (
    .sample_clock       (sample_clock),
    .resetn             (resetn),
    .serial_in          (serial_in),
    .read_not_ready_in  (read_not_ready_in),
    .RCV_datareg        (RCV_datareg),
    .read_not_ready_out (read_not_ready_out),
    .error1             (error1),
    .error2             (error2)
  );

  // Free-running sample clock, 10 time units per cycle.
  initial begin
    sample_clock = 1'b0;
    forever #5 sample_clock = ~sample_clock;
  end

  // Cycle counter used to time the completion pulse.
  always @(posedge sample_clock) cyc <= cyc + 1;

  // Count completion pulses (one per high cycle) away from the active edge.
  always @(negedge sample_clock) begin
    if (read_not_ready_out) begin
      pulse_cnt = pulse_cnt + 1;
      pulse_cyc = cyc;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared = compared + 1;
    if (got !== exp) begin
      mismatched = mismatched + 1;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Send one frame; called at a negedge. The stop level is held only through
  // its mid-bit sample so a low stop bit does not trigger a new start.
  task automatic applyStimulus(input logic [WS-1:0] data, input logic stop_bit);
    serial_in = 1'b0;
    start_cyc = cyc + 1;
    repeat (OS) @(negedge sample_clock);
    for (int i = 0; i < WS; i++) begin
      serial_in = data[i];
      repeat (OS) @(negedge sample_clock);
    end
    serial_in = stop_bit;
    repeat (OS / 2 + 1) @(negedge sample_clock);
    serial_in = 1'b1;
    repeat (OS / 2 - 1) @(negedge sample_clock);
    repeat (4) @(negedge sample_clock);
  endtask

  initial begin
    compared          = 0;
    mismatched        = 0;
    cyc               = 0;
    pulse_cnt         = 0;
    pulse_cyc         = 0;
    start_cyc         = 0;
    resetn            = 1'b1;
    serial_in         = 1'b1;
    read_not_ready_in = 1'b0;

    // Reset values visible before any clock edge
    #1;
    checkOutput("reset_data", 32'(RCV_datareg), 32'h00);
    checkOutput("reset_pulse", 32'(read_not_ready_out), 32'd0);
    checkOutput("reset_err1", 32'(error1), 32'd0);
    checkOutput("reset_err2", 32'(error2), 32'd0);

    repeat (2) @(negedge sample_clock);
    resetn = 1'b0;
    repeat (3) @(negedge sample_clock);

    // Good frame 0xA5
    applyStimulus(8'hA5, 1'b1);
    checkOutput("good_data", 32'(RCV_datareg), 32'hA5);
    checkOutput("good_pulses", 32'(pulse_cnt), 32'd1);
    checkOutput("good_latency", 32'(pulse_cyc - start_cyc), 32'(EXP_LATENCY));
    checkOutput("good_err1", 32'(error1), 32'd0);
    checkOutput("good_err2", 32'(error2), 32'd0);

    // Overrun: host still busy at the stop sample
    read_not_ready_in = 1'b1;
    applyStimulus(8'h3C, 1'b1);
    read_not_ready_in = 1'b0;
    checkOutput("ovr_err1", 32'(error1), 32'd1);
    checkOutput("ovr_data", 32'(RCV_datareg), 32'hA5);
    checkOutput("ovr_pulses", 32'(pulse_cnt), 32'd1);

    // A start edge clears the sticky overrun flag (one-cycle glitch)
    serial_in = 1'b0;
    @(negedge sample_clock);
    checkOutput("ovr_clear_err1", 32'(error1), 32'd0);
    serial_in = 1'b1;
    repeat (4) @(negedge sample_clock);

    // Framing error: stop bit low
    applyStimulus(8'h0F, 1'b0);
    checkOutput("frm_err2", 32'(error2), 32'd1);
    checkOutput("frm_err1", 32'(error1), 32'd0);
    checkOutput("frm_data", 32'(RCV_datareg), 32'hA5);
    checkOutput("frm_pulses", 32'(pulse_cnt), 32'd1);

    // Glitch: two low samples then high
    serial_in = 1'b0;
    repeat (2) @(negedge sample_clock);
    serial_in = 1'b1;
    repeat (6) @(negedge sample_clock);
    checkOutput("glitch_err1", 32'(error1), 32'd0);
    checkOutput("glitch_err2", 32'(error2), 32'd0);
    checkOutput("glitch_data", 32'(RCV_datareg), 32'hA5);
    checkOutput("glitch_pulses", 32'(pulse_cnt), 32'd1);

    applyStimulus(8'h81, 1'b1);
    checkOutput("f81_data", 32'(RCV_datareg), 32'h81);
    checkOutput("f81_pulses", 32'(pulse_cnt), 32'd2);

    // Reset in the middle of data bit 4 of 0xFF
    serial_in = 1'b0;
    repeat (OS) @(negedge sample_clock);
    serial_in = 1'b1;
    repeat (4 * OS + OS / 2) @(negedge sample_clock);
    #2;
    resetn = 1'b1;
    #1;
    checkOutput("midrst_data", 32'(RCV_datareg), 32'h00);
    checkOutput("midrst_pulse", 32'(read_not_ready_out), 32'd0);
    checkOutput("midrst_err1", 32'(error1), 32'd0);
    checkOutput("midrst_err2", 32'(error2), 32'd0);
    @(negedge sample_clock);
    resetn = 1'b0;
    repeat (3 * OS) @(negedge sample_clock);

    applyStimulus(8'h55, 1'b1);
    checkOutput("f55_data", 32'(RCV_datareg), 32'h55);
    checkOutput("f55_pulses", 32'(pulse_cnt), 32'd3);
    checkOutput("f55_err1", 32'(error1), 32'd0);
    checkOutput("f55_err2", 32'(error2), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
